sample_writer: RTL and testbench
================================

# sample_writer

Upstream feeder for DSP data memory bank I. Accepts a valid/ready stream of 16-bit receiver samples and writes them into bank I SRAM as two ping-pong frame buffers. The DSP is told when a frame is complete and releases it when it is done. The block backpressures the stream while both buffers are held by the DSP. Samples are never dropped.

## Interface
- BASE_ADDR, 0: bank I word address of buffer 0.
- FRAME_LEN, 1024: samples per frame. Buffer 1 base = BASE_ADDR+FRAME_LEN.
- Parameter constraints: FRAME_LEN ≥ 2 and BASE_ADDR+2·FRAME_LEN ≤ 2^`SRAM_ADDR_LEN`.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; low → sample_ready low, all state held.
- sample_data  in  `REG_WORD_LEN` (16)  incoming sample.
- sample_valid  in  1  sample_data valid.
- sample_ready  out  1  block can accept a sample this cycle.
- write_addr  out  `SRAM_ADDR_LEN` (15)  bank I write address.
- write_data  out  `REG_WORD_LEN` (16)  bank I write data.
- write_en  out  1  bank I write strobe, one cycle per sample.
- frame_ready  out  1  one-cycle pulse: a buffer is complete and in SRAM.
- frame_base  out  `SRAM_ADDR_LEN`  base address of the buffer just completed; holds until the next frame_ready.
- frame_ack  in  1  DSP releases a buffer (single-cycle pulse).
- frame_ack_buf  in  1  index of the buffer being released.
- buf_full  out  2  per-buffer held-by-DSP flags.

## Operation
- State:
  - wr_buf (1 bit): current fill buffer.
  - cnt (0..FRAME_LEN-1): offset within the fill buffer.
  - full[1:0]: per-buffer held flags.
  - pending_done: one-cycle delay flag for the frame_ready pulse.
- sample_ready = enable & ~full[wr_buf]. This is combinational from registered state, so ready never depends on sample_valid.
- Accept = sample_valid & sample_ready. On accept, at the next edge:
  - write_en ← 1, write_addr ← BASE_ADDR + wr_buf·FRAME_LEN + cnt, write_data ← sample_data.
  - cnt ← cnt+1.
- Cycles with no accept: write_en ← 0. write_addr and write_data hold their last values.
- Last sample of a frame (accept with cnt == FRAME_LEN-1):
  - full[wr_buf] ← 1, wr_buf toggles, cnt ← 0.
  - pending_done ← 1 and frame_base ← that buffer's base.
  - The following cycle, frame_ready = 1 and pending_done clears.
- frame_ack clears full[frame_ack_buf] at the next edge.
  - An ack to a buffer that is not full is ignored.
  - An ack in the same cycle that fills the other buffer: both take effect.
- Both buffers full: sample_ready is 0 until an ack arrives. After an ack of buffer wr_buf, sample_ready is 1 in the cycle after the ack edge.
- enable low mid-frame: cnt, wr_buf and full are held. Capture resumes at the same offset when enable returns high. Acks are still processed while enable is low.
- Reset (async assert, any time, including mid-frame):
  - Outputs: sample_ready=0, write_en=0, write_addr=BASE_ADDR, write_data=0, frame_ready=0, frame_base=BASE_ADDR, buf_full=2'b00.
  - Internal state: wr_buf=0, cnt=0, pending_done=0.
  - Partial frame is discarded. An in-flight write_en is deasserted immediately.

## Timing
- Accept edge N → write_en high during cycle N+1 with stable address and data. SRAM write completes at edge N+1.
- Last write of a frame during cycle N+1 → frame_ready high during cycle N+2. The frame's data is therefore valid in SRAM when the DSP sees the pulse.
- Throughput: one sample per cycle while a buffer is free. There is no bubble at a buffer switch when the next buffer is free.
- Ack edge M → buf_full bit low in cycle M+1. sample_ready may rise in the same cycle M+1.
- frame_ack_buf is sampled only when frame_ack=1.

## Test plan
- Reset, enable=1, continuous valid, FRAME_LEN=4, samples 10..13:
  - writes addr 0..3 with data 10..13 on consecutive cycles.
  - frame_ready one cycle after the addr-3 write, frame_base=0, buf_full=01.
- Continue with samples 14..17:
  - writes addr 4..7 with no bubble.
  - second frame_ready with frame_base=4, buf_full=11.
  - sample_ready drops to 0 the cycle after the addr-7 accept. Sample 18 is held, not written.
- With both buffers full, frame_ack with frame_ack_buf=0:
  - buf_full=10 next cycle, sample_ready=1.
  - sample 18 is written to addr 0.
- Ack to buffer 1 while it is not full, plus enable toggled low for 3 cycles mid-frame at cnt=2:
  - ack has no effect.
  - no writes while enable is low; resume writes at offset 2.
- Assert rst during the write_en cycle of offset 2:
  - write_en drops immediately, all outputs take reset values.
  - after release, the next sample is written to addr BASE_ADDR.
- Fill-and-ack collision: the last sample of buffer 1 is accepted in the same cycle as frame_ack for buffer 0:
  - buf_full=10 next cycle.
  - wr_buf=0 and sample_ready stays 1.

Source files
------------

// File: rtl/sample_writer_if.sv
// Stream, SRAM-write and frame-handshake signals between sample_writer and its
// neighbours: the sample source, bank I SRAM and the DSP.
interface sample_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
);
  logic                     enable;
  logic signed [DATA_W-1:0] sample_data;
  logic                     sample_valid;
  logic                     sample_ready;
  logic [ADDR_W-1:0]        write_addr;
  logic signed [DATA_W-1:0] write_data;
  logic                     write_en;
  logic                     frame_ready;
  logic [ADDR_W-1:0]        frame_base;
  logic                     frame_ack;
  logic                     frame_ack_buf;
  logic [1:0]               buf_full;

  modport master (
    output enable, sample_data, sample_valid, frame_ack, frame_ack_buf,
    input  sample_ready, write_addr, write_data, write_en,
           frame_ready, frame_base, buf_full
  );

  modport slave (
    input  enable, sample_data, sample_valid, frame_ack, frame_ack_buf,
    output sample_ready, write_addr, write_data, write_en,
           frame_ready, frame_base, buf_full
  );
endinterface

// File: rtl/sample_writer.sv
// Writes a valid/ready sample stream into two ping-pong frame buffers in bank I
// SRAM, signals each completed frame to the DSP and stalls while both are held.
module sample_writer #(
  parameter int BASE_ADDR = 0,
  parameter int FRAME_LEN = 1024,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15
) (
  input logic           clk,
  input logic           rst,
  sample_writer_if.slave bus
);

  localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE0    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE1    = ADDR_W'(BASE_ADDR + FRAME_LEN);

  logic                     wr_buf;
  logic [CNT_W-1:0]         cnt;
  logic [1:0]               full;
  logic [1:0]               full_nxt;
  logic                     pending_done;
  logic                     accept_p0;
  logic                     last_p0;
  logic [ADDR_W-1:0]        buf_base_p0;
  logic [ADDR_W-1:0]        write_addr_p1;
  logic signed [DATA_W-1:0] write_data_p1;
  logic                     vld_p1;
  logic [ADDR_W-1:0]        frame_base_p1;
  logic                     frame_ready_p2;

  // Stage 0: ready is a function of registered state only; reset forces it low.
  assign bus.sample_ready = rst & bus.enable & ~full[wr_buf];
  assign accept_p0        = bus.sample_valid & bus.sample_ready;
  assign last_p0          = accept_p0 && (cnt == CNT_LAST);
  assign buf_base_p0      = wr_buf ? BASE1 : BASE0;

  // Clear-then-set: an ack can never cancel a fill of the same buffer because
  // the buffer being filled is by construction not held.
  always_comb begin
    full_nxt = full;
    if (bus.frame_ack) full_nxt[bus.frame_ack_buf] = 1'b0;
    if (last_p0)       full_nxt[wr_buf]            = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_buf         <= 1'b0;
      cnt            <= '0;
      full           <= 2'b00;
      pending_done   <= 1'b0;
      vld_p1         <= 1'b0;
      write_addr_p1  <= BASE0;
      write_data_p1  <= '0;
      frame_base_p1  <= BASE0;
      frame_ready_p2 <= 1'b0;
    end else begin
      full           <= full_nxt;
      vld_p1         <= accept_p0;
      frame_ready_p2 <= pending_done;
      pending_done   <= last_p0;
      if (accept_p0) begin
        write_addr_p1 <= buf_base_p0 + ADDR_W'(cnt);
        write_data_p1 <= bus.sample_data;
        cnt           <= last_p0 ? '0 : cnt + CNT_W'(1);
      end
      if (last_p0) begin
        wr_buf        <= ~wr_buf;
        frame_base_p1 <= buf_base_p0;
      end
    end
  end

  // Stage 1: SRAM write port; stage 2: frame-complete pulse after the last write.
  assign bus.write_en    = vld_p1;
  assign bus.write_addr  = write_addr_p1;
  assign bus.write_data  = write_data_p1;
  assign bus.frame_base  = frame_base_p1;
  assign bus.frame_ready = frame_ready_p2;
  assign bus.buf_full    = full;

endmodule

// File: tb/tb_sample_writer.sv
// Directed bench for sample_writer with FRAME_LEN=4, BASE_ADDR=0.
module tb_sample_writer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  sample_writer_if #(.DATA_W(16), .ADDR_W(15)) bus ();

  sample_writer #(
    .BASE_ADDR(0),
    .FRAME_LEN(4),
    .DATA_W   (16),
    .ADDR_W   (15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_write(input string tag, input logic en, input int addr, input int data);
    check({tag, "_we"}, 32'(bus.write_en), 32'(en));
    if (en) begin
      check({tag, "_addr"}, 32'(bus.write_addr), 32'(addr));
      check({tag, "_data"}, 32'(bus.write_data), 32'(data));
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ready"}, 32'(bus.sample_ready), 32'(0));
    check({tag, "_we"},    32'(bus.write_en),     32'(0));
    check({tag, "_addr"},  32'(bus.write_addr),   32'(0));
    check({tag, "_data"},  32'(bus.write_data),   32'(0));
    check({tag, "_frdy"},  32'(bus.frame_ready),  32'(0));
    check({tag, "_fbase"}, 32'(bus.frame_base),   32'(0));
    check({tag, "_full"},  32'(bus.buf_full),     32'(0));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.enable = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data = '0;
    bus.frame_ack = 1'b0;
    bus.frame_ack_buf = 1'b0;
    #1;
    chk_reset("por");
    step();
    step();
    rst = 1'b1;

    // Two back-to-back frames, samples 10..17.
    bus.enable = 1'b1;
    bus.sample_valid = 1'b1;
    #1;
    check("ready_start", 32'(bus.sample_ready), 32'(1));
    for (int i = 0; i < 8; i++) begin
      bus.sample_data = 16'(10 + i);
      step();
      chk_write("f01", 1'b1, i, 10 + i);
      check("f01_frdy", 32'(bus.frame_ready), 32'(i == 4));
      if (i == 4) begin
        check("f0_base", 32'(bus.frame_base), 32'(0));
        check("f0_full", 32'(bus.buf_full), 32'(1));
      end
    end
    check("both_full", 32'(bus.buf_full), 32'(3));
    check("stall_ready", 32'(bus.sample_ready), 32'(0));

    bus.sample_data = 16'(18);
    step();
    chk_write("stall0", 1'b0, 0, 0);
    check("f1_frdy", 32'(bus.frame_ready), 32'(1));
    check("f1_base", 32'(bus.frame_base), 32'(4));
    check("stall_full", 32'(bus.buf_full), 32'(3));
    check("hold_addr", 32'(bus.write_addr), 32'(7));
    check("hold_data", 32'(bus.write_data), 32'(17));
    step();
    chk_write("stall1", 1'b0, 0, 0);
    check("frdy_pulse", 32'(bus.frame_ready), 32'(0));

    // Release buffer 0.
    bus.frame_ack = 1'b1;
    bus.frame_ack_buf = 1'b0;
    step();
    bus.frame_ack = 1'b0;
    check("ack0_full", 32'(bus.buf_full), 32'(2));
    check("ack0_ready", 32'(bus.sample_ready), 32'(1));
    chk_write("ack0", 1'b0, 0, 0);
    step();
    chk_write("s18", 1'b1, 0, 18);

    // Release buffer 1 alongside sample 19.
    bus.sample_data = 16'(19);
    bus.frame_ack = 1'b1;
    bus.frame_ack_buf = 1'b1;
    step();
    chk_write("s19", 1'b1, 1, 19);
    check("ack1_full", 32'(bus.buf_full), 32'(0));

    // Spurious ack to buffer 1 plus enable low for 3 cycles at offset 2.
    bus.sample_data = 16'(20);
    bus.enable = 1'b0;
    #1;
    check("en_lo_ready", 32'(bus.sample_ready), 32'(0));
    for (int j = 0; j < 3; j++) begin
      step();
      bus.frame_ack = 1'b0;
      chk_write("en_lo", 1'b0, 0, 0);
      check("spur_full", 32'(bus.buf_full), 32'(0));
    end
    bus.enable = 1'b1;
    #1;
    check("en_hi_ready", 32'(bus.sample_ready), 32'(1));
    step();
    chk_write("s20", 1'b1, 2, 20);

    // Asynchronous reset during the offset-2 write cycle.
    #2;
    rst = 1'b0;
    #1;
    chk_reset("rst_mid");
    bus.sample_valid = 1'b0;
    step();
    rst = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_data = 16'(21);
    step();
    chk_write("s21", 1'b1, 0, 21);

    // Finish buffer 0, fill buffer 1, ack buffer 0 on buffer 1's last sample.
    for (int k = 0; k < 7; k++) begin
      bus.sample_data = 16'(22 + k);
      if (k == 6) begin
        bus.frame_ack = 1'b1;
        bus.frame_ack_buf = 1'b0;
      end
      step();
      bus.frame_ack = 1'b0;
      chk_write("coll", 1'b1, 1 + k, 22 + k);
      if (k == 2) check("c0_full", 32'(bus.buf_full), 32'(1));
      if (k == 3) begin
        check("c0_frdy", 32'(bus.frame_ready), 32'(1));
        check("c0_base", 32'(bus.frame_base), 32'(0));
      end
    end
    check("coll_full", 32'(bus.buf_full), 32'(2));
    check("coll_ready", 32'(bus.sample_ready), 32'(1));

    bus.sample_valid = 1'b0;
    step();
    chk_write("coll_idle", 1'b0, 0, 0);
    check("c1_frdy", 32'(bus.frame_ready), 32'(1));
    check("c1_base", 32'(bus.frame_base), 32'(4));
    check("c1_full", 32'(bus.buf_full), 32'(2));

    bus.sample_valid = 1'b1;
    bus.sample_data = 16'(29);
    step();
    chk_write("s29", 1'b1, 0, 29);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
